// File: rtl/strobe_rx_pkg.sv
// Shared types and constants for the strobed-RX to AXI-Stream bridge.
package strobe_rx_pkg;

  // Bridge control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    OVR   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // A programmed packet length below this value is treated as this value,
  // so pkt_len of 0 and 1 both produce single-sample packets.
  localparam int unsigned MIN_PKT_LEN = 1;

  // Width and ceiling of the optional dropped-sample counter
  localparam int unsigned OVR_CNT_W = 16;
  localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = '1;

endpackage

// File: rtl/strobe_rx_fifo.sv
// Synchronous FIFO with a registered head word. The head register always
// mirrors the oldest stored entry, so the output is a flop from the cycle
// after the push edge. Capacity is exactly 2^AW entries in total.
module strobe_rx_fifo #(
  parameter int DW = 33,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] out_q;
  logic          do_push;
  logic          do_pop;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign do_pop      = pop && !empty;
  // A pop frees its slot in the same cycle, so a full FIFO still accepts a push
  assign do_push     = push && (!full || do_pop);
  assign rd_next_ptr = rd_ptr + AW'(1);
  assign dout        = out_q;

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and the registered head word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_q  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      out_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_next_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (do_pop) begin
        if (count == CNT_ONE) begin
          if (do_push) begin
            out_q <= din;
          end
        end else begin
          out_q <= mem[rd_next_ptr];
        end
      end else if (do_push && empty) begin
        out_q <= din;
      end
    end
  end

endmodule

// File: rtl/strobe_rx_to_axi.sv
// Converts the radio frontend's run/strobe/sample interface into framed
// AXI-Stream. Each sample waits in a holding register until the next strobe
// (or the end of the burst) decides whether it closes a packet, then moves
// into a small FIFO together with its tlast bit.
// Optional feature: define STROBE_RX_OVR_CNT_EN to add the ovr_count output.
module strobe_rx_to_axi
  import strobe_rx_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FIFO_AW = 4,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic             strobe,
  input  logic [WIDTH-1:0] sample,
  input  logic [LEN_W-1:0] pkt_len,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             overrun,
  output logic             err,
  output logic             busy
`ifdef STROBE_RX_OVR_CNT_EN
  ,
  output logic [OVR_CNT_W-1:0] ovr_count
`endif
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] hold_data;
  logic             hold_v;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_last;
  logic [LEN_W-1:0] len_eff;
  logic             run_q;

  logic             start;
  logic             push;
  logic             push_last;
  logic             load_hold;
  logic             drop_hold;
  logic             ovr_event;

  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             can_push;

  assign len_eff  = (pkt_len < LEN_W'(MIN_PKT_LEN)) ? LEN_W'(MIN_PKT_LEN) : pkt_len;
  assign o_tvalid = !fifo_empty;
  assign pop      = o_tvalid && o_tready;
  assign can_push = !fifo_full || pop;
  assign busy     = (state != IDLE) || !fifo_empty;

  strobe_rx_fifo #(
    .DW (WIDTH + 1),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .din     ({push_last, hold_data}),
    .pop     (pop),
    .dout    ({o_tlast, o_tdata}),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register; clear overrides every other event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the per-cycle push / load / overrun decisions
  always_comb begin
    state_next = state;
    start      = 1'b0;
    push       = 1'b0;
    push_last  = 1'b0;
    load_hold  = 1'b0;
    drop_hold  = 1'b0;
    ovr_event  = 1'b0;
    case (state)
      IDLE: begin
        if (run && !run_q) begin
          start      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (!run) begin
          if (!hold_v) begin
            state_next = DRAIN;
          end else if (can_push) begin
            push       = 1'b1;
            push_last  = 1'b1;
            drop_hold  = 1'b1;
            state_next = DRAIN;
          end else begin
            // Burst ended against a full FIFO: let OVR close the packet later
            state_next = OVR;
          end
        end else if (strobe) begin
          if (!hold_v) begin
            load_hold = 1'b1;
          end else if (can_push) begin
            push      = 1'b1;
            push_last = (cnt == len_last);
            load_hold = 1'b1;
          end else begin
            ovr_event  = 1'b1;
            state_next = OVR;
          end
        end
      end
      OVR: begin
        if (hold_v) begin
          if (can_push) begin
            push      = 1'b1;
            push_last = 1'b1;
            drop_hold = 1'b1;
          end
        end else if (!run) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holding register, packet counter, error flag and edge detector
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_data <= '0;
      hold_v    <= 1'b0;
      cnt       <= '0;
      len_last  <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      run_q     <= 1'b1;
    end else if (clear) begin
      hold_v    <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      overrun   <= 1'b0;
      run_q     <= run;
    end else begin
      overrun <= ovr_event;
      // Holding run_q low in DRAIN makes a run level still high on return
      // to IDLE look like a fresh rising edge
      run_q   <= (state == DRAIN) ? 1'b0 : run;
      if (start) begin
        len_last <= len_eff - LEN_W'(1);
        cnt      <= '0;
        err      <= 1'b0;
        hold_v   <= 1'b0;
      end
      if (ovr_event) begin
        err <= 1'b1;
      end
      if (push) begin
        cnt <= push_last ? '0 : cnt + LEN_W'(1);
      end
      if (load_hold) begin
        hold_data <= sample;
        hold_v    <= 1'b1;
      end else if (drop_hold) begin
        hold_v <= 1'b0;
      end
    end
  end

`ifdef STROBE_RX_OVR_CNT_EN
  logic                 drop;
  logic [OVR_CNT_W-1:0] ovr_cnt_q;

  assign drop = run && strobe &&
                ((state == OVR) || ((state == RUN) && hold_v && !can_push));
  assign ovr_count = ovr_cnt_q;

  // Saturating tally of dropped strobes, reset together with err
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= '0;
    end else if (clear || start) begin
      ovr_cnt_q <= '0;
    end else if (drop && (ovr_cnt_q != OVR_CNT_MAX)) begin
      ovr_cnt_q <= ovr_cnt_q + OVR_CNT_W'(1);
    end
  end
`endif

endmodule
